platform_scroller: RTL and testbench

Vertical scroll engine for the ten platforms. Once per video frame it moves every platform down by the doodler's overshoot above the scroll line. It wraps platforms that leave the bottom back to the top and accumulates the score. It directly feeds the platform x-position randomiser: its `plat_y*` outputs drive that block's `y1..y10`, and its `score` drives that block's `score`. The randomiser rerolls a platform's x on every clock where that platform's y is greater than 479.

---
 rtl/doodle_pkg.sv | 17 +
 rtl/platform_slot.sv | 29 ++
 rtl/platform_scroller.sv | 127 ++++++++++++
 tb/tb_platform_scroller.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/doodle_pkg.sv
// rtl/doodle_pkg.sv - shared game-state encodings, widths and scroll FSM states
package doodle_pkg;

    localparam logic [1:0] ST_MENU = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd2;

    localparam int SCREEN_H = 480;
    localparam int Y_W      = 9;
    localparam int SCORE_W  = 14;

    typedef enum logic [1:0] {
        SCR_IDLE   = 2'd0,
        SCR_SCROLL = 2'd1,
        SCR_WRAP   = 2'd2
    } scroll_state_t;

endpackage

// File: rtl/platform_slot.sv
// rtl/platform_slot.sv - one platform y register with layout reload, step add and bottom wrap
module platform_slot
    import doodle_pkg::*;
#(
    parameter logic [Y_W-1:0] INIT_Y = '0,
    parameter int             WRAP_H = SCREEN_H
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_il,
    input  logic           add_step,
    input  logic [3:0]     step,
    input  logic           wrap,
    output logic [Y_W-1:0] y
);

    localparam logic [Y_W-1:0] H = Y_W'(WRAP_H);

    always_ff @(posedge clk) begin
        if (rst || load_il) begin
            y <= INIT_Y;
        end else if (add_step) begin
            y <= y + Y_W'(step);
        end else if (wrap && (y >= H)) begin
            y <= y - H;
        end
    end

endmodule

// File: rtl/platform_scroller.sv
// rtl/platform_scroller.sv - per-frame vertical scroll, wrap and score for ten platforms
module platform_scroller #(
    parameter int SCREEN_H    = 480,
    parameter int SCROLL_LINE = 200,
    parameter int MAX_STEP    = 8,
    parameter int SPACING     = 48,
    parameter int SCORE_MAX   = 9999
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       state,
    input  logic                             frame_tick,
    input  logic [doodle_pkg::Y_W-1:0]       doodle_y,
    input  logic                             doodle_rising,
    output logic [doodle_pkg::Y_W-1:0]       plat_y1,
    output logic [doodle_pkg::Y_W-1:0]       plat_y2,
    output logic [doodle_pkg::Y_W-1:0]       plat_y3,
    output logic [doodle_pkg::Y_W-1:0]       plat_y4,
    output logic [doodle_pkg::Y_W-1:0]       plat_y5,
    output logic [doodle_pkg::Y_W-1:0]       plat_y6,
    output logic [doodle_pkg::Y_W-1:0]       plat_y7,
    output logic [doodle_pkg::Y_W-1:0]       plat_y8,
    output logic [doodle_pkg::Y_W-1:0]       plat_y9,
    output logic [doodle_pkg::Y_W-1:0]       plat_y10,
    output logic [doodle_pkg::SCORE_W-1:0]   score,
    output logic [3:0]                       scroll_px,
    output logic                             scroll_valid
);
    import doodle_pkg::*;

    scroll_state_t   cur_q, nxt;
    logic [3:0]      step_q, step_calc;
    logic            latch_step, load_il, add_step, do_wrap;
    logic [Y_W-1:0]  diff;
    logic [SCORE_W:0] score_sum;
    logic [Y_W-1:0]  y_q [10];

    assign diff      = Y_W'(SCROLL_LINE) - doodle_y;
    assign score_sum = {1'b0, score} + (SCORE_W + 1)'(step_q);

    // Overshoot above the scroll line, clamped; only while the doodler is rising
    always_comb begin
        step_calc = 4'd0;
        if (doodle_rising && (doodle_y < Y_W'(SCROLL_LINE))) begin
            step_calc = (diff > Y_W'(MAX_STEP)) ? 4'(MAX_STEP) : diff[3:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cur_q <= SCR_IDLE;
        else     cur_q <= nxt;
    end

    always_comb begin
        nxt        = cur_q;
        latch_step = 1'b0;
        load_il    = 1'b0;
        add_step   = 1'b0;
        do_wrap    = 1'b0;
        case (cur_q)
            SCR_IDLE: begin
                if (state == ST_MENU) begin
                    load_il = 1'b1;
                end else if (frame_tick && (state == ST_PLAY)) begin
                    latch_step = 1'b1;
                    nxt        = SCR_SCROLL;
                end
            end
            SCR_SCROLL: begin
                add_step = 1'b1;
                nxt      = SCR_WRAP;
            end
            SCR_WRAP: begin
                do_wrap = 1'b1;
                nxt     = SCR_IDLE;
            end
            default: nxt = SCR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_q       <= 4'd0;
            score        <= '0;
            scroll_px    <= 4'd0;
            scroll_valid <= 1'b0;
        end else begin
            scroll_px    <= 4'd0;
            scroll_valid <= 1'b0;
            if (latch_step) step_q <= step_calc;
            if (load_il)    score  <= '0;
            if (add_step) begin
                score        <= (score_sum > (SCORE_W + 1)'(SCORE_MAX)) ?
                                SCORE_W'(SCORE_MAX) : score_sum[SCORE_W-1:0];
                scroll_px    <= step_q;
                scroll_valid <= (step_q != 4'd0);
            end
        end
    end

    for (genvar i = 0; i < 10; i++) begin : g_slot
        platform_slot #(
            .INIT_Y (Y_W'(i * SPACING)),
            .WRAP_H (SCREEN_H)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load_il  (load_il),
            .add_step (add_step),
            .step     (step_q),
            .wrap     (do_wrap),
            .y        (y_q[i])
        );
    end

    assign plat_y1  = y_q[0];
    assign plat_y2  = y_q[1];
    assign plat_y3  = y_q[2];
    assign plat_y4  = y_q[3];
    assign plat_y5  = y_q[4];
    assign plat_y6  = y_q[5];
    assign plat_y7  = y_q[6];
    assign plat_y8  = y_q[7];
    assign plat_y9  = y_q[8];
    assign plat_y10 = y_q[9];

endmodule

// File: tb/tb_platform_scroller.sv
// tb/tb_platform_scroller.sv - randomized self-checking bench for platform_scroller
module tb_platform_scroller;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  state;
    logic        frame_tick;
    logic [8:0]  doodle_y;
    logic        doodle_rising;
    logic [8:0]  plat_y1, plat_y2, plat_y3, plat_y4, plat_y5;
    logic [8:0]  plat_y6, plat_y7, plat_y8, plat_y9, plat_y10;
    logic [13:0] score;
    logic [3:0]  scroll_px;
    logic        scroll_valid;

    logic [8:0]  y_out [10];

    int n_checks = 0;
    int n_fail   = 0;

    int mdl_y [10];
    int mdl_score;
    int exp_step;
    int exp_s [10];
    int exp_w [10];

    logic [8:0]  obs_s [10];
    logic [8:0]  obs_w [10];
    logic [3:0]  obs_px;
    logic        obs_valid;
    logic [13:0] obs_score;

    platform_scroller dut (
        .clk           (clk),
        .rst           (rst),
        .state         (state),
        .frame_tick    (frame_tick),
        .doodle_y      (doodle_y),
        .doodle_rising (doodle_rising),
        .plat_y1       (plat_y1),
        .plat_y2       (plat_y2),
        .plat_y3       (plat_y3),
        .plat_y4       (plat_y4),
        .plat_y5       (plat_y5),
        .plat_y6       (plat_y6),
        .plat_y7       (plat_y7),
        .plat_y8       (plat_y8),
        .plat_y9       (plat_y9),
        .plat_y10      (plat_y10),
        .score         (score),
        .scroll_px     (scroll_px),
        .scroll_valid  (scroll_valid)
    );

    assign y_out[0] = plat_y1;
    assign y_out[1] = plat_y2;
    assign y_out[2] = plat_y3;
    assign y_out[3] = plat_y4;
    assign y_out[4] = plat_y5;
    assign y_out[5] = plat_y6;
    assign y_out[6] = plat_y7;
    assign y_out[7] = plat_y8;
    assign y_out[8] = plat_y9;
    assign y_out[9] = plat_y10;

    always #5 clk = ~clk;

    function automatic int ref_step(input int dy, input bit rising);
        if (rising && dy < 200) return (200 - dy > 8) ? 8 : 200 - dy;
        return 0;
    endfunction

    task automatic model_il();
        for (int i = 0; i < 10; i++) mdl_y[i] = i * 48;
        mdl_score = 0;
    endtask

    task automatic model_frame(input int dy, input bit rising);
        exp_step = ref_step(dy, rising);
        for (int i = 0; i < 10; i++) begin
            mdl_y[i] += exp_step;
            exp_s[i] = mdl_y[i];
            if (mdl_y[i] >= 480) mdl_y[i] -= 480;
            exp_w[i] = mdl_y[i];
        end
        mdl_score = (mdl_score + exp_step > 9999) ? 9999 : mdl_score + exp_step;
    endtask

    // Starts and ends on a falling edge; captures the SCROLL and WRAP results
    task automatic run_frame(input logic [8:0] dy, input logic rising);
        doodle_y      = dy;
        doodle_rising = rising;
        frame_tick    = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        obs_px    = scroll_px;
        obs_valid = scroll_valid;
        obs_score = score;
        for (int i = 0; i < 10; i++) obs_s[i] = y_out[i];
        @(negedge clk);
        for (int i = 0; i < 10; i++) obs_w[i] = y_out[i];
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; state = 2'd0; frame_tick = 1'b0; doodle_y = 9'd0; doodle_rising = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (y_out[i] !== 9'(i * 48)) begin
                n_fail++;
                $display("FAIL reset_plat_y%0d: got %0d expected %0d", i + 1, y_out[i], i * 48);
            end
        end
        n_checks++;
        if (score !== 14'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score); end
        n_checks++;
        if (scroll_valid !== 1'b0 || scroll_px !== 4'd0) begin
            n_fail++; $display("FAIL reset_scroll: got valid=%b px=%0d expected 0/0", scroll_valid, scroll_px);
        end
        rst = 1'b0;
        model_il();
    endtask

    task automatic test_clamped();
        state = 2'd2;
        model_frame(150, 1'b1);
        run_frame(9'd150, 1'b1);
        n_checks++;
        if (obs_px !== 4'd8 || obs_valid !== 1'b1) begin
            n_fail++; $display("FAIL clamped_scroll: got px=%0d valid=%b expected 8/1", obs_px, obs_valid);
        end
        n_checks++;
        if (obs_s[0] !== 9'd8 || obs_s[9] !== 9'd440) begin
            n_fail++; $display("FAIL clamped_y: got y1=%0d y10=%0d expected 8/440", obs_s[0], obs_s[9]);
        end
        n_checks++;
        if (obs_score !== 14'd8) begin n_fail++; $display("FAIL clamped_score: got %0d expected 8", obs_score); end
        n_checks++;
        if (obs_w[9] !== 9'd440) begin n_fail++; $display("FAIL clamped_wrap_y10: got %0d expected 440", obs_w[9]); end
    endtask

    task automatic test_reset_mid_scroll();
        doodle_y = 9'd150; doodle_rising = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_il();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (y_out[i] !== 9'(mdl_y[i])) begin
                n_fail++; $display("FAIL midreset_plat_y%0d: got %0d expected %0d", i + 1, y_out[i], mdl_y[i]);
            end
        end
        n_checks++;
        if (score !== 14'd0 || scroll_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_score: got score=%0d valid=%b expected 0/0", score, scroll_valid);
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_wrap();
        int steps [6] = '{8, 8, 8, 8, 8, 4};
        state = 2'd0;
        @(negedge clk);
        model_il();
        state = 2'd2;
        foreach (steps[k]) begin
            model_frame(200 - steps[k], 1'b1);
            run_frame(9'(200 - steps[k]), 1'b1);
        end
        n_checks++;
        if (obs_w[9] !== 9'd476) begin n_fail++; $display("FAIL wrap_preload_y10: got %0d expected 476", obs_w[9]); end
        model_frame(197, 1'b1);
        run_frame(9'd197, 1'b1);
        n_checks++;
        if (obs_s[9] !== 9'd479 || obs_w[9] !== 9'd479) begin
            n_fail++; $display("FAIL wrap_edge_479: got scroll=%0d wrap=%0d expected 479/479", obs_s[9], obs_w[9]);
        end
        model_frame(195, 1'b1);
        run_frame(9'd195, 1'b1);
        n_checks++;
        if (obs_s[9] !== 9'd484) begin n_fail++; $display("FAIL wrap_scroll_y10: got %0d expected 484", obs_s[9]); end
        n_checks++;
        if (obs_w[9] !== 9'd4) begin n_fail++; $display("FAIL wrap_wrap_y10: got %0d expected 4", obs_w[9]); end
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (obs_w[i] !== 9'(exp_w[i])) begin
                n_fail++; $display("FAIL wrap_plat_y%0d: got %0d expected %0d", i + 1, obs_w[i], exp_w[i]);
            end
        end
        n_checks++;
        if (score !== 14'(mdl_score)) begin n_fail++; $display("FAIL wrap_score: got %0d expected %0d", score, mdl_score); end
    endtask

    task automatic test_no_scroll();
        int dys [2]  = '{250, 150};
        bit  ris [2] = '{1'b1, 1'b0};
        state = 2'd2;
        foreach (dys[k]) begin
            model_frame(dys[k], ris[k]);
            run_frame(9'(dys[k]), ris[k]);
            n_checks++;
            if (obs_valid !== 1'b0 || obs_px !== 4'd0) begin
                n_fail++; $display("FAIL noscroll_valid%0d: got valid=%b px=%0d expected 0/0", k, obs_valid, obs_px);
            end
            n_checks++;
            if (obs_score !== 14'(mdl_score)) begin
                n_fail++; $display("FAIL noscroll_score%0d: got %0d expected %0d", k, obs_score, mdl_score);
            end
            for (int i = 0; i < 10; i++) begin
                n_checks++;
                if (obs_w[i] !== 9'(mdl_y[i])) begin
                    n_fail++; $display("FAIL noscroll_plat_y%0d: got %0d expected %0d", i + 1, obs_w[i], mdl_y[i]);
                end
            end
        end
    endtask

    task automatic test_gating();
        state = 2'd3;
        for (int k = 0; k < 3; k++) begin
            run_frame(9'd150, 1'b1);
            n_checks++;
            if (obs_valid !== 1'b0 || obs_score !== 14'(mdl_score)) begin
                n_fail++; $display("FAIL hold_tick%0d: got valid=%b score=%0d expected 0/%0d", k, obs_valid, obs_score, mdl_score);
            end
            for (int i = 0; i < 10; i++) begin
                n_checks++;
                if (obs_w[i] !== 9'(mdl_y[i])) begin
                    n_fail++; $display("FAIL hold_plat_y%0d: got %0d expected %0d", i + 1, obs_w[i], mdl_y[i]);
                end
            end
        end
        state = 2'd0;
        @(negedge clk);
        @(negedge clk);
        model_il();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (y_out[i] !== 9'(mdl_y[i])) begin
                n_fail++; $display("FAIL menu_plat_y%0d: got %0d expected %0d", i + 1, y_out[i], mdl_y[i]);
            end
        end
        n_checks++;
        if (score !== 14'd0) begin n_fail++; $display("FAIL menu_score: got %0d expected 0", score); end
        // Tick held across SCROLL and WRAP: only the first edge counts
        state = 2'd2; doodle_y = 9'd150; doodle_rising = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        model_frame(150, 1'b1);
        n_checks++;
        if (plat_y1 !== 9'(mdl_y[0]) || score !== 14'(mdl_score)) begin
            n_fail++; $display("FAIL double_tick: got y1=%0d score=%0d expected %0d/%0d", plat_y1, score, mdl_y[0], mdl_score);
        end
        // Hold entered right after the tick: scroll still completes
        doodle_y = 9'd196; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0; state = 2'd3;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        model_frame(196, 1'b1);
        n_checks++;
        if (plat_y10 !== 9'(mdl_y[9]) || score !== 14'(mdl_score)) begin
            n_fail++; $display("FAIL hold_midscroll: got y10=%0d score=%0d expected %0d/%0d", plat_y10, score, mdl_y[9], mdl_score);
        end
        state = 2'd2;
    endtask

    task automatic test_random();
        int dy;
        bit rising;
        state = 2'd2;
        for (int k = 0; k < 60; k++) begin
            dy     = int'($urandom_range(140, 260));
            rising = 1'($urandom_range(0, 1));
            model_frame(dy, rising);
            run_frame(9'(dy), rising);
            n_checks++;
            if (obs_px !== 4'(exp_step) || obs_valid !== (exp_step != 0)) begin
                n_fail++; $display("FAIL rand_scroll%0d: got px=%0d valid=%b expected %0d", k, obs_px, obs_valid, exp_step);
            end
            n_checks++;
            if (obs_score !== 14'(mdl_score)) begin
                n_fail++; $display("FAIL rand_score%0d: got %0d expected %0d", k, obs_score, mdl_score);
            end
            for (int i = 0; i < 10; i++) begin
                n_checks++;
                if (obs_s[i] !== 9'(exp_s[i]) || obs_w[i] !== 9'(exp_w[i])) begin
                    n_fail++;
                    $display("FAIL rand_plat_y%0d_f%0d: got %0d/%0d expected %0d/%0d",
                             i + 1, k, obs_s[i], obs_w[i], exp_s[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int need;
        state = 2'd2;
        while (mdl_score + 8 <= 9995) begin
            model_frame(150, 1'b1);
            run_frame(9'd150, 1'b1);
            n_checks++;
            if (obs_score !== 14'(mdl_score)) begin
                n_fail++; $display("FAIL sat_ramp: got %0d expected %0d", obs_score, mdl_score);
            end
        end
        need = 9995 - mdl_score;
        if (need > 0) begin
            model_frame(200 - need, 1'b1);
            run_frame(9'(200 - need), 1'b1);
        end
        n_checks++;
        if (score !== 14'd9995) begin n_fail++; $display("FAIL sat_9995: got %0d expected 9995", score); end
        for (int k = 0; k < 2; k++) begin
            model_frame(150, 1'b1);
            run_frame(9'd150, 1'b1);
            n_checks++;
            if (obs_score !== 14'd9999) begin
                n_fail++; $display("FAIL sat_9999_%0d: got %0d expected 9999", k, obs_score);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clamped();
        test_reset_mid_scroll();
        test_wrap();
        test_no_scroll();
        test_gating();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
